// File: rtl/game_sprite_display_anim_pkg.sv
// ---------------------------------------------------------------------------
// game_sprite_display_anim_pkg
// Shared display configuration for the sprite renderers: colour widths,
// screen geometry and beam coordinate widths, plus a small helper that
// sizes index registers so they never collapse to zero bits.
// ---------------------------------------------------------------------------
package game_sprite_display_anim_pkg;

    localparam int RGB_WIDTH     = 3;
    localparam int ERGB_WIDTH    = 1 + RGB_WIDTH;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int X_WIDTH       = 10;
    localparam int Y_WIDTH       = 10;

    // Width of a counter holding values 0..n-1, at least one bit.
    function automatic int minWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_sprite_anim_counter.sv
// ---------------------------------------------------------------------------
// game_sprite_anim_counter
// Animation timebase: counts screen frames while animation is enabled and
// steps the frame index once every FRAME_PERIOD of them, wrapping at
// N_FRAMES (which need not be a power of two).
//   clk, reset        clock, asynchronous active-high reset
//   i_frame_start     one-cycle strobe at the start of each screen frame
//   i_anim_en         allow the period counter to advance
//   i_anim_restart    return to frame 0 with a fresh period, any cycle
//   o_frame_index     current animation frame
// ---------------------------------------------------------------------------
module game_sprite_anim_counter
    import game_sprite_display_anim_pkg::*;
#(
    parameter int N_FRAMES     = 4,
    parameter int FRAME_PERIOD = 8,
    localparam int FIW         = minWidth(N_FRAMES)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_frame_start,
    input  logic           i_anim_en,
    input  logic           i_anim_restart,
    output logic [FIW-1:0] o_frame_index
);

    localparam int             PW     = minWidth(FRAME_PERIOD);
    localparam logic [PW-1:0]  P_LAST = PW'(FRAME_PERIOD - 1);
    localparam logic [FIW-1:0] F_LAST = FIW'(N_FRAMES - 1);

    logic [PW-1:0]  r_period;
    logic [FIW-1:0] r_frame;

    // Restart wins over a simultaneous advance; the frame index wraps
    // explicitly so non-power-of-two frame counts never reach unused codes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period <= '0;
            r_frame  <= '0;
        end else if (i_anim_restart) begin
            r_period <= '0;
            r_frame  <= '0;
        end else if (i_frame_start && i_anim_en) begin
            if (r_period == P_LAST) begin
                r_period <= '0;
                r_frame  <= (r_frame == F_LAST) ? '0 : r_frame + 1'b1;
            end else begin
                r_period <= r_period + 1'b1;
            end
        end
    end

    assign o_frame_index = r_frame;

endmodule

// File: rtl/game_sprite_display_anim.sv
// ---------------------------------------------------------------------------
// game_sprite_display_anim
// Animated sprite renderer. Position and mirroring are latched once per
// screen frame so a sprite never tears mid-screen; the pixel path is a
// two-stage pipeline (hit/address, then bitmap lookup).
//   clk, reset                      clock, asynchronous active-high reset
//   i_pixel_x, i_pixel_y            current beam position
//   i_frame_start                   start-of-frame strobe
//   i_sprite_x, i_sprite_y          requested top-left corner
//   i_mirror_x                      draw horizontally flipped
//   i_anim_en, i_anim_restart       animation control
//   o_sprite_within_screen          whole sprite lies on screen
//   o_sprite_out_left/right/top/bottom  latched sprite bounds
//   o_frame_index                   current animation frame
//   o_rgb_en, o_rgb                 opaque pixel hit and its colour (t+2)
// ---------------------------------------------------------------------------
module game_sprite_display_anim
    import game_sprite_display_anim_pkg::*;
#(
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int N_FRAMES      = 4,
    parameter int FRAME_PERIOD  = 8,
    parameter logic [N_FRAMES*SPRITE_HEIGHT*SPRITE_WIDTH*ERGB_WIDTH-1:0] BITMAP = '0,
    localparam int FIW          = minWidth(N_FRAMES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [X_WIDTH-1:0]   i_pixel_x,
    input  logic [Y_WIDTH-1:0]   i_pixel_y,
    input  logic                 i_frame_start,
    input  logic [X_WIDTH-1:0]   i_sprite_x,
    input  logic [Y_WIDTH-1:0]   i_sprite_y,
    input  logic                 i_mirror_x,
    input  logic                 i_anim_en,
    input  logic                 i_anim_restart,
    output logic                 o_sprite_within_screen,
    output logic [X_WIDTH-1:0]   o_sprite_out_left,
    output logic [X_WIDTH-1:0]   o_sprite_out_right,
    output logic [Y_WIDTH-1:0]   o_sprite_out_top,
    output logic [Y_WIDTH-1:0]   o_sprite_out_bottom,
    output logic [FIW-1:0]       o_frame_index,
    output logic                 o_rgb_en,
    output logic [RGB_WIDTH-1:0] o_rgb
);

    localparam int CW     = $clog2(SPRITE_WIDTH);
    localparam int RW     = $clog2(SPRITE_HEIGHT);
    localparam int TOTAL  = N_FRAMES * SPRITE_HEIGHT * SPRITE_WIDTH;
    localparam int IDX_W  = FIW + RW + CW;
    localparam int OFF_W  = $clog2(TOTAL * ERGB_WIDTH);
    localparam int XE     = X_WIDTH + 1;
    localparam int YE     = Y_WIDTH + 1;

    localparam logic [XE-1:0]    X_SPAN    = XE'(SPRITE_WIDTH - 1);
    localparam logic [YE-1:0]    Y_SPAN    = YE'(SPRITE_HEIGHT - 1);
    localparam logic [XE-1:0]    X_LIMIT   = XE'(SCREEN_WIDTH - 1);
    localparam logic [YE-1:0]    Y_LIMIT   = YE'(SCREEN_HEIGHT - 1);
    localparam logic [CW-1:0]    COL_LAST  = CW'(SPRITE_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(TOTAL - 1);

    logic [X_WIDTH-1:0]   r_posX;
    logic [Y_WIDTH-1:0]   r_posY;
    logic                 r_mirror;
    logic [FIW-1:0]       w_frameIndex;

    logic [XE-1:0]        w_dx, w_dxEnd, w_rightExt;
    logic [YE-1:0]        w_dy, w_dyEnd, w_bottomExt;
    logic                 w_hit;
    logic [CW-1:0]        w_col;

    logic                 r_s1Hit;
    logic [FIW-1:0]       r_s1Frame;
    logic [RW-1:0]        r_s1Row;
    logic [CW-1:0]        r_s1Col;

    logic [IDX_W-1:0]     w_revIdx;
    logic [OFF_W-1:0]     w_bitOff;
    logic [ERGB_WIDTH-1:0] w_ergb;
    logic                 w_opaque;

    logic                 r_rgbEn;
    logic [RGB_WIDTH-1:0] r_rgb;
    logic                 r_within;
    logic [X_WIDTH-1:0]   r_left, r_right;
    logic [Y_WIDTH-1:0]   r_top, r_bottom;
    logic                 w_unused;

    // Shadow copies of the game-logic inputs, refreshed only at frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_posX   <= '0;
            r_posY   <= '0;
            r_mirror <= 1'b0;
        end else if (i_frame_start) begin
            r_posX   <= i_sprite_x;
            r_posY   <= i_sprite_y;
            r_mirror <= i_mirror_x;
        end
    end

    game_sprite_anim_counter #(
        .N_FRAMES     (N_FRAMES),
        .FRAME_PERIOD (FRAME_PERIOD)
    ) u_animCounter (
        .clk            (clk),
        .reset          (reset),
        .i_frame_start  (i_frame_start),
        .i_anim_en      (i_anim_en),
        .i_anim_restart (i_anim_restart),
        .o_frame_index  (w_frameIndex)
    );

    // One extra bit on every subtraction acts as the borrow: a pixel is
    // inside when neither "pixel - left" nor "right - pixel" goes negative.
    assign w_dx        = {1'b0, i_pixel_x} - {1'b0, r_posX};
    assign w_dxEnd     = {1'b0, r_posX} + X_SPAN - {1'b0, i_pixel_x};
    assign w_dy        = {1'b0, i_pixel_y} - {1'b0, r_posY};
    assign w_dyEnd     = {1'b0, r_posY} + Y_SPAN - {1'b0, i_pixel_y};
    assign w_hit       = ~w_dx[X_WIDTH] & ~w_dxEnd[X_WIDTH] &
                         ~w_dy[Y_WIDTH] & ~w_dyEnd[Y_WIDTH];
    assign w_col       = r_mirror ? (COL_LAST - w_dx[CW-1:0]) : w_dx[CW-1:0];

    // Stage 1 captures everything the lookup needs, so a frame start that
    // lands behind a pixel cannot alter how that pixel is drawn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1Hit   <= 1'b0;
            r_s1Frame <= '0;
            r_s1Row   <= '0;
            r_s1Col   <= '0;
        end else begin
            r_s1Hit   <= w_hit;
            r_s1Frame <= w_frameIndex;
            r_s1Row   <= w_dy[RW-1:0];
            r_s1Col   <= w_col;
        end
    end

    // Power-of-two dimensions make the linear pixel index a concatenation;
    // frame 0 row 0 col 0 lives at the top of BITMAP, hence the reversal.
    assign w_revIdx = IDX_LAST - {r_s1Frame, r_s1Row, r_s1Col};
    assign w_bitOff = OFF_W'(w_revIdx) * OFF_W'(ERGB_WIDTH);
    assign w_ergb   = BITMAP[w_bitOff +: ERGB_WIDTH];
    assign w_opaque = r_s1Hit & w_ergb[ERGB_WIDTH-1];

    // Stage 2: colour only moves on an opaque hit; otherwise it is stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgbEn <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_rgbEn <= w_opaque;
            if (w_opaque) begin
                r_rgb <= w_ergb[RGB_WIDTH-1:0];
            end
        end
    end

    // Bounds for the collision logic, registered from the shadow position.
    assign w_rightExt  = {1'b0, r_posX} + X_SPAN;
    assign w_bottomExt = {1'b0, r_posY} + Y_SPAN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_within <= 1'b0;
            r_left   <= '0;
            r_right  <= '0;
            r_top    <= '0;
            r_bottom <= '0;
        end else begin
            r_within <= (w_rightExt <= X_LIMIT) && (w_bottomExt <= Y_LIMIT);
            r_left   <= r_posX;
            r_right  <= w_rightExt[X_WIDTH-1:0];
            r_top    <= r_posY;
            r_bottom <= w_bottomExt[Y_WIDTH-1:0];
        end
    end

    // Middle bits of the offsets only matter through the borrow bits.
    assign w_unused = ^{w_dx, w_dy, w_dxEnd, w_dyEnd};

    assign o_sprite_within_screen = r_within;
    assign o_sprite_out_left      = r_left;
    assign o_sprite_out_right     = r_right;
    assign o_sprite_out_top       = r_top;
    assign o_sprite_out_bottom    = r_bottom;
    assign o_frame_index          = w_frameIndex;
    assign o_rgb_en               = r_rgbEn;
    assign o_rgb                  = r_rgb;

endmodule
